s_history_downsampler: RTL and testbench

- Upstream feeder of the multi-clock FIR adder tree.
- Collects the N-bit control-signal vector s_in once per accepted sample into a K-deep history shift register.
- Every DOWNSAMPLE accepted samples, once the history is full, takes a stable snapshot S_matrix and pulses start for one cycle.
- Guarantees the adder gets at least ADDER_CYCLES clocks per computation; starts that would violate this are dropped and flagged.

---
 rtl/s_history_downsampler_pkg.sv | 14 +
 rtl/s_history_downsampler_start_interval_guard.sv | 63 ++++++
 rtl/s_history_downsampler.sv | 108 ++++++++++
 tb/tb_s_history_downsampler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s_history_downsampler_pkg.sv
// Shared types, defaults and counter-width helper for the s-history downsampler.
package s_history_downsampler_pkg;

    localparam int N_DEFAULT = 8;
    localparam int DS_FACTOR = 4;

    typedef logic [N_DEFAULT-1:0] s_vec_t;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/s_history_downsampler_start_interval_guard.sv
// Enforces the minimum spacing between start pulses and records starts that
// had to be dropped because the downstream adder was still busy.
module s_history_downsampler_start_interval_guard
    import s_history_downsampler_pkg::*;
#(
    parameter int ADDER_CYCLES = 16,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fire_req,
    input  logic                  overrun_clr,
    output logic                  fire_ok,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] dropped_cnt
);

    localparam int            GW      = cnt_w(ADDER_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(ADDER_CYCLES - 1);

    logic [GW-1:0]         gap_q, gap_d;
    logic                  overrun_q, overrun_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    // gap_q saturates at GAP_MAX, so equality is the ">= ADDER_CYCLES-1" test.
    assign fire_ok = fire_req && (gap_q == GAP_MAX);

    always_comb begin
        gap_d     = gap_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        if (fire_ok) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GW'(1);
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
            drop_d    = '0;
        end else if (fire_req && !fire_ok) begin
            overrun_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            gap_q     <= GAP_MAX;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            gap_q     <= gap_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign overrun     = overrun_q;
    assign dropped_cnt = drop_q;

endmodule

// File: rtl/s_history_downsampler.sv
// K-deep history of control vectors; every DOWNSAMPLE accepted samples (once full)
// it snapshots the history into S_matrix and pulses start for the FIR adder tree.
module s_history_downsampler
    import s_history_downsampler_pkg::*;
#(
    parameter int K            = 256,
    parameter int N            = N_DEFAULT,
    parameter int DOWNSAMPLE   = DS_FACTOR,
    parameter int ADDER_CYCLES = 16,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [N-1:0]          s_in,
    input  logic                  s_valid,
    input  logic                  flush,
    input  logic                  overrun_clr,
    output logic [N-1:0]          S_matrix [K-1:0],
    output logic                  start,
    output logic                  filled,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] dropped_cnt
);

    localparam int            FW        = cnt_w(K);
    localparam int            DW        = cnt_w(DOWNSAMPLE - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(K);
    localparam logic [FW-1:0] FILL_LAST = FW'(K - 1);
    localparam logic [DW-1:0] DS_LAST   = DW'(DOWNSAMPLE - 1);

    logic [N-1:0]  hist_q     [K-1:0];
    logic [N-1:0]  hist_d     [K-1:0];
    logic [N-1:0]  hist_shift [K-1:0];
    logic [N-1:0]  smat_q     [K-1:0];
    logic [FW-1:0] fill_q, fill_d;
    logic [DW-1:0] ds_q, ds_d;
    logic          filled_q;
    logic          start_q;
    logic          accept;
    logic          fire_req;
    logic          fire_ok;

    assign accept   = s_valid && !flush;
    // fill_q >= K-1 means the history is full once this sample is shifted in.
    assign fire_req = accept && (ds_q == DS_LAST) && (fill_q >= FILL_LAST);

    always_comb begin
        hist_shift[0] = s_in;
        for (int k = 1; k < K; k++) begin
            hist_shift[k] = hist_q[k-1];
        end
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        ds_d   = ds_q;
        if (flush) begin
            hist_d = '{default: '0};
            fill_d = '0;
            ds_d   = '0;
        end else if (s_valid) begin
            hist_d = hist_shift;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
            ds_d = (ds_q == DS_LAST) ? '0 : ds_q + DW'(1);
        end
    end

    s_history_downsampler_start_interval_guard #(
        .ADDER_CYCLES (ADDER_CYCLES),
        .DROP_CNT_W   (DROP_CNT_W)
    ) u_guard (
        .clk         (clk),
        .resetn      (resetn),
        .fire_req    (fire_req),
        .overrun_clr (overrun_clr),
        .fire_ok     (fire_ok),
        .overrun     (overrun),
        .dropped_cnt (dropped_cnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist_q   <= '{default: '0};
            smat_q   <= '{default: '0};
            fill_q   <= '0;
            ds_q     <= '0;
            filled_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            ds_q     <= ds_d;
            filled_q <= (fill_d == FILL_MAX);
            start_q  <= fire_ok;
            if (fire_ok) begin
                smat_q <= hist_shift;
            end
        end
    end

    assign S_matrix = smat_q;
    assign start    = start_q;
    assign filled   = filled_q;

endmodule

// File: tb/tb_s_history_downsampler.sv
// Bench for s_history_downsampler: three configurations driven by directed vectors,
// checked every cycle against a timestamp/queue model plus hand-computed literals.
module tb_s_history_downsampler;

    localparam int K  = 8;
    localparam int N  = 3;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn  [NI];
    logic         sval  [NI];
    logic         flsh  [NI];
    logic         oclr  [NI];
    logic [N-1:0] sin   [NI];
    logic [N-1:0] smat  [NI][K-1:0];
    logic         start_w  [NI];
    logic         filled_w [NI];
    logic         ovr_w    [NI];
    logic [15:0]  dcnt     [NI];

    // Instance 0: DS=2, AC=4.  Instance 1: DS=2, AC=7.  Instance 2: DS=1, AC=1.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        s_history_downsampler #(
            .K            (K),
            .N            (N),
            .DOWNSAMPLE   (g == 2 ? 1 : 2),
            .ADDER_CYCLES (g == 0 ? 4 : (g == 1 ? 7 : 1)),
            .DROP_CNT_W   (16)
        ) u_dut (
            .clk         (clk),
            .resetn      (rstn[g]),
            .s_in        (sin[g]),
            .s_valid     (sval[g]),
            .flush       (flsh[g]),
            .overrun_clr (oclr[g]),
            .S_matrix    (smat[g]),
            .start       (start_w[g]),
            .filled      (filled_w[g]),
            .overrun     (ovr_w[g]),
            .dropped_cnt (dcnt[g])
        );
    end

    function automatic int ds_of(input int g);
        return (g == 2) ? 1 : 2;
    endfunction

    function automatic int ac_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 7 : 1);
    endfunction

    // Model: samples since flush, newest-first history, start timestamps.
    int m_n     [NI];
    int m_hist  [NI][K];
    int m_smat  [NI][K];
    bit m_start [NI];
    bit m_filled[NI];
    bit m_ovr   [NI];
    int m_dcnt  [NI];
    int m_last  [NI];
    int cyc = 0;

    always @(posedge clk) begin
        bit fire;
        cyc++;
        for (int g = 0; g < NI; g++) begin
            if (!rstn[g]) begin
                m_n[g] = 0;
                for (int k = 0; k < K; k++) begin
                    m_hist[g][k] = 0;
                    m_smat[g][k] = 0;
                end
                m_start[g]  = 0;
                m_filled[g] = 0;
                m_ovr[g]    = 0;
                m_dcnt[g]   = 0;
                m_last[g]   = cyc - 1000;
            end else begin
                m_start[g] = 0;
                fire = sval[g] && !flsh[g] && (m_n[g] % ds_of(g) == ds_of(g) - 1)
                       && (m_n[g] >= K - 1);
                if (flsh[g]) begin
                    m_n[g] = 0;
                    for (int k = 0; k < K; k++) m_hist[g][k] = 0;
                    m_filled[g] = 0;
                end else if (sval[g]) begin
                    for (int k = K - 1; k > 0; k--) m_hist[g][k] = m_hist[g][k-1];
                    m_hist[g][0] = int'(sin[g]);
                    m_n[g]++;
                    m_filled[g] = (m_n[g] >= K);
                end
                if (fire) begin
                    if (cyc - m_last[g] >= ac_of(g)) begin
                        for (int k = 0; k < K; k++) m_smat[g][k] = m_hist[g][k];
                        m_start[g] = 1;
                        m_last[g]  = cyc;
                    end else if (!oclr[g]) begin
                        m_ovr[g] = 1;
                        if (m_dcnt[g] < 65535) m_dcnt[g]++;
                    end
                end
                if (oclr[g]) begin
                    m_ovr[g]  = 0;
                    m_dcnt[g] = 0;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input int g, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", nm, g, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                check("start", g, 64'(start_w[g]), 64'(m_start[g]));
                check("filled", g, 64'(filled_w[g]), 64'(m_filled[g]));
                check("overrun", g, 64'(ovr_w[g]), 64'(m_ovr[g]));
                check("dropped_cnt", g, 64'(dcnt[g]), 64'(m_dcnt[g]));
                for (int k = 0; k < K; k++) begin
                    check("S_matrix", g, 64'(smat[g][k]), 64'(m_smat[g][k]));
                end
            end
        end
    end

    // Called at a negedge; applies inputs for the next rising edge, returns at the following negedge.
    task automatic drive(input int g, input bit v, input int s, input bit f, input bit c);
        #1;
        rstn[g] = 1'b1;
        sval[g] = v;
        sin[g]  = N'(s);
        flsh[g] = f;
        oclr[g] = c;
        @(negedge clk);
    endtask

    task automatic rst_pulse(input int g);
        #1;
        rstn[g] = 1'b0;
        sval[g] = 1'b0;
        flsh[g] = 1'b0;
        oclr[g] = 1'b0;
        @(negedge clk);
    endtask

    // Continuous samples 1..12 into instance 0 straight after reset.
    task automatic fill_seq0();
        for (int i = 1; i <= 7; i++) drive(0, 1, i, 0, 0);
        check("lit_filled_after7", 0, 64'(filled_w[0]), 64'd0);
        check("lit_start_after7", 0, 64'(start_w[0]), 64'd0);
        drive(0, 1, 8, 0, 0);
        check("lit_start_after8", 0, 64'(start_w[0]), 64'd1);
        check("lit_filled_after8", 0, 64'(filled_w[0]), 64'd1);
        check("lit_smat0_after8", 0, 64'(smat[0][0]), 64'd0);
        check("lit_smat1_after8", 0, 64'(smat[0][1]), 64'd7);
        check("lit_smat7_after8", 0, 64'(smat[0][7]), 64'd1);
        drive(0, 1, 9, 0, 0);
        drive(0, 1, 10, 0, 0);
        check("lit_start_after10", 0, 64'(start_w[0]), 64'd0);
        check("lit_ovr_after10", 0, 64'(ovr_w[0]), 64'd1);
        check("lit_dcnt_after10", 0, 64'(dcnt[0]), 64'd1);
        drive(0, 1, 11, 0, 0);
        drive(0, 1, 12, 0, 0);
        check("lit_start_after12", 0, 64'(start_w[0]), 64'd1);
        check("lit_smat0_after12", 0, 64'(smat[0][0]), 64'd4);
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            rstn[g] = 1'b0;
            sval[g] = 1'b0;
            flsh[g] = 1'b0;
            oclr[g] = 1'b0;
            sin[g]  = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        for (int g = 0; g < NI; g++) begin
            check("lit_reset_start", g, 64'(start_w[g]), 64'd0);
            check("lit_reset_dcnt", g, 64'(dcnt[g]), 64'd0);
        end

        // Continuous fill, first start, then a drop and a start.
        fill_seq0();

        // Clear overrun, flush, then one sample every third cycle.
        drive(0, 0, 0, 0, 1);
        check("lit_ovr_clr", 0, 64'(ovr_w[0]), 64'd0);
        check("lit_dcnt_clr", 0, 64'(dcnt[0]), 64'd0);
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            drive(0, 1, i + 2, 0, 0);
            if (i == 8 || i == 10 || i == 12) begin
                check("lit_sparse_start", 0, 64'(start_w[0]), 64'd1);
            end
            drive(0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
        check("lit_sparse_ovr", 0, 64'(ovr_w[0]), 64'd0);

        // Flush coinciding with a valid sample of value 7.
        drive(0, 1, 7, 1, 0);
        check("lit_flush_filled", 0, 64'(filled_w[0]), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, (i <= 6) ? i : 11 - i, 0, 0);
            if (i == 7) check("lit_flush_nostart", 0, 64'(start_w[0]), 64'd0);
        end
        check("lit_flush_start", 0, 64'(start_w[0]), 64'd1);
        check("lit_flush_smat7", 0, 64'(smat[0][7]), 64'd1);
        check("lit_flush_smat0", 0, 64'(smat[0][0]), 64'd3);

        // Build up a drop, get a start, reset two cycles later.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 2, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        drive(0, 1, 3, 0, 0);
        drive(0, 1, 4, 0, 0);
        check("lit_pre_reset_start", 0, 64'(start_w[0]), 64'd1);
        check("lit_pre_reset_dcnt", 0, 64'(dcnt[0]), 64'd1);
        drive(0, 0, 0, 0, 0);
        rst_pulse(0);
        check("lit_rst_start", 0, 64'(start_w[0]), 64'd0);
        check("lit_rst_filled", 0, 64'(filled_w[0]), 64'd0);
        check("lit_rst_ovr", 0, 64'(ovr_w[0]), 64'd0);
        check("lit_rst_dcnt", 0, 64'(dcnt[0]), 64'd0);
        for (int k = 0; k < K; k++) check("lit_rst_smat", 0, 64'(smat[0][k]), 64'd0);
        fill_seq0();

        // Instance 1: starts too close together are dropped.
        for (int i = 1; i <= 14; i++) begin
            drive(1, 1, i, 0, 0);
            if (i == 8) check("lit_b_first_start", 1, 64'(start_w[1]), 64'd1);
        end
        check("lit_b_ovr", 1, 64'(ovr_w[1]), 64'd1);
        check("lit_b_dcnt", 1, 64'(dcnt[1]), 64'd3);
        check("lit_b_start14", 1, 64'(start_w[1]), 64'd0);
        drive(1, 0, 0, 0, 1);
        check("lit_b_clr_ovr", 1, 64'(ovr_w[1]), 64'd0);
        check("lit_b_clr_dcnt", 1, 64'(dcnt[1]), 64'd0);
        drive(1, 1, 15, 0, 0);
        drive(1, 1, 16, 0, 0);
        check("lit_b_start16", 1, 64'(start_w[1]), 64'd1);
        drive(1, 1, 17, 0, 0);
        drive(1, 1, 18, 0, 1);
        check("lit_b_clr_wins_ovr", 1, 64'(ovr_w[1]), 64'd0);
        check("lit_b_clr_wins_dcnt", 1, 64'(dcnt[1]), 64'd0);
        drive(1, 0, 0, 0, 0);

        // Instance 2: DOWNSAMPLE=1, ADDER_CYCLES=1, start every cycle once full.
        for (int i = 1; i <= 12; i++) begin
            drive(2, 1, i, 0, 0);
            check("lit_c_start", 2, 64'(start_w[2]), (i >= 8) ? 64'd1 : 64'd0);
            if (i >= 8) check("lit_c_smat0", 2, 64'(smat[2][0]), 64'(i % 8));
        end
        drive(2, 0, 0, 0, 0);
        check("lit_c_idle_start", 2, 64'(start_w[2]), 64'd0);

        drive(0, 0, 0, 0, 0);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
